// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO: any depth, programmable almost flags, standard or FWFT read, flush, sticky errors.
// Define FIFO_SYNC_PROG_PEAK_EN to add the peak_cnt/peak_clr occupancy tracker.
module fifo_sync_prog #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned FWFT  = 0,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic [CW-1:0]    ae_thresh,
    input  logic [CW-1:0]    af_thresh,
    output logic             empty,
    output logic             almost_empty,
    output logic             full,
    output logic             almost_full,
    output logic [CW-1:0]    data_cnt,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_SYNC_PROG_PEAK_EN
    ,
    input  logic             peak_clr,
    output logic [CW-1:0]    peak_cnt
`endif
);

    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [PW-1:0] LastPtr  = PW'(DEPTH - 1);
    localparam bit            Fwft     = (FWFT != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc, rd_acc, load, arr_avail;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty      = Fwft ? !rd_valid_q : (cnt_q == '0);
        full       = (cnt_q == DepthCnt);
        // In FWFT mode the count includes the output stage; the array has data beyond it.
        arr_avail  = Fwft ? (cnt_q > CW'(rd_valid_q)) : 1'b0;
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        load       = Fwft ? (arr_avail && (!rd_valid_q || rd_acc)) : rd_acc;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            rd_data_d  = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (load) begin
                rd_ptr_d  = ptr_inc(rd_ptr_q);
                rd_data_d = mem_q[rd_ptr_q];
            end
            rd_valid_d = Fwft ? (load || (rd_valid_q && !rd_acc)) : rd_acc;
            if (wr_acc && !rd_acc) begin
                cnt_d = cnt_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (wr_en && full) begin
                ovf_d = 1'b1;
            end
            if (rd_en && empty) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign data_cnt     = cnt_q;
    assign almost_empty = (cnt_q <= ae_thresh);
    assign almost_full  = (cnt_q >= af_thresh);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

`ifdef FIFO_SYNC_PROG_PEAK_EN
    logic [CW-1:0] peak_q, peak_d;

    // Tracks the registered count, so the peak lags a count change by one cycle.
    always_comb begin
        peak_d = peak_q;
        if (peak_clr) begin
            peak_d = cnt_q;
        end else if (cnt_q > peak_q) begin
            peak_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_cnt = peak_q;
`endif

endmodule
